// File: rtl/wb_pkg.sv
// Shared types and opcode constants for the writeback-port arbiter.
package wb_pkg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  funct3;
    } lq_entry_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;

endpackage

// File: rtl/wb_load_fifo.sv
// Load-return FIFO; full/empty come from pointers that carry one extra wrap bit.
module wb_load_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_push,
    input  lq_entry_t i_wdata,
    input  logic      i_pop,
    output lq_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    lq_entry_t   r_mem [DEPTH];
    logic        w_do_push;
    logic        w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    // A full FIFO refuses a push even when a pop frees a slot in the same cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: ALU stream vs. buffered load returns, plus load scoreboard.
// Optional starvation guard for queued loads: define WB_STARVE_GUARD_EN.
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned LQ_DEPTH   = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_stall,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    input  logic [2:0]  ld_funct3,
    input  logic        iss_valid,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        RegWrite,
    output logic [4:0]  WB_rd_addr,
    output logic [31:0] WB_rd_data,
    output logic [2:0]  funct3,
    output logic [6:0]  opcode
);

    lq_entry_t   w_head;
    lq_entry_t   w_push_entry;
    logic        w_full;
    logic        w_empty;
    logic        w_force;
    logic        w_alu_gnt;
    logic        w_ld_gnt;
    logic [31:0] r_sb;
    logic [31:0] w_sb_next;

    assign w_push_entry = '{rd: ld_rd, data: ld_data, funct3: ld_funct3};

    wb_load_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (ld_valid),
        .i_wdata (w_push_entry),
        .i_pop   (w_ld_gnt),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] r_starve;

    assign w_force   = !w_empty && (r_starve == SW'(STARVE_MAX));
    assign alu_stall = w_force && alu_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
        end else if (w_empty || w_ld_gnt) begin
            r_starve <= '0;
        end else if (r_starve != SW'(STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    logic w_unused_starve;
    assign w_unused_starve = (STARVE_MAX != 0);
    assign w_force   = 1'b0;
    assign alu_stall = 1'b0;
`endif

    assign w_alu_gnt = alu_valid && !w_force;
    assign w_ld_gnt  = !w_empty && (!alu_valid || w_force);
    assign ld_ready  = !w_full;

    // Set after clear so a same-cycle issue to the retiring register keeps it busy.
    always_comb begin
        w_sb_next = r_sb;
        if (w_ld_gnt)  w_sb_next[w_head.rd] = 1'b0;
        if (iss_valid) w_sb_next[iss_rd]    = 1'b1;
        w_sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sb <= '0;
        else        r_sb <= w_sb_next;
    end

    assign rs1_busy = r_sb[rs1_addr];
    assign rs2_busy = r_sb[rs2_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite   <= 1'b0;
            WB_rd_addr <= '0;
            WB_rd_data <= '0;
            funct3     <= '0;
            opcode     <= '0;
        end else begin
            RegWrite <= 1'b0;
            if (w_alu_gnt) begin
                if (alu_rd != 5'd0) begin
                    RegWrite   <= 1'b1;
                    WB_rd_addr <= alu_rd;
                    WB_rd_data <= alu_data;
                    funct3     <= 3'b000;
                    opcode     <= OP_RTYPE;
                end
            end else if (w_ld_gnt) begin
                if (w_head.rd != 5'd0) begin
                    RegWrite   <= 1'b1;
                    WB_rd_addr <= w_head.rd;
                    WB_rd_data <= w_head.data;
                    funct3     <= w_head.funct3;
                    opcode     <= OP_LOAD;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: queue-based reference model plus directed literal checks.
module tb_wb_port_arbiter;

    localparam int LQ_DEPTH   = 2;
    localparam int STARVE_MAX = 4;
`ifdef WB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [2:0]  ld_funct3;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        RegWrite;
    logic [4:0]  WB_rd_addr;
    logic [31:0] WB_rd_data;
    logic [2:0]  funct3;
    logic [6:0]  opcode;

    wb_port_arbiter #(.LQ_DEPTH(LQ_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .alu_stall  (alu_stall),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .ld_funct3  (ld_funct3),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .RegWrite   (RegWrite),
        .WB_rd_addr (WB_rd_addr),
        .WB_rd_data (WB_rd_data),
        .funct3     (funct3),
        .opcode     (opcode)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: loads kept as a queue, scoreboard as a bit vector.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [2:0]  f3;
    } ent_t;

    ent_t        m_q[$];
    logic [31:0] m_sb;
    int          m_cnt;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [2:0]  m_f3;
    logic [6:0]  m_op;

    function automatic bit m_force();
        return GUARD && (m_q.size() != 0) && (m_cnt == STARVE_MAX);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit   frc, lw, was_empty, was_full;
        ent_t h;
        if (!rst_n) begin
            m_q.delete();
            m_sb   = '0;
            m_cnt  = 0;
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_f3   = '0;
            m_op   = '0;
        end else begin
            frc       = m_force();
            was_empty = (m_q.size() == 0);
            was_full  = (m_q.size() >= LQ_DEPTH);
            lw        = !was_empty && (!alu_valid || frc);
            m_we      = 1'b0;
            if (alu_valid && !frc) begin
                if (alu_rd != 0) begin
                    m_we = 1'b1; m_addr = alu_rd; m_data = alu_data;
                    m_f3 = 3'b000; m_op = 7'b0110011;
                end
            end else if (lw) begin
                h = m_q.pop_front();
                if (h.rd != 0) begin
                    m_we = 1'b1; m_addr = h.rd; m_data = h.data;
                    m_f3 = h.f3; m_op = 7'b0000011;
                end
                m_sb[h.rd] = 1'b0;
            end
            if (lw || was_empty)         m_cnt = 0;
            else if (m_cnt < STARVE_MAX) m_cnt++;
            if (iss_valid && iss_rd != 0) m_sb[iss_rd] = 1'b1;
            if (ld_valid && !was_full) m_q.push_back('{rd: ld_rd, data: ld_data, f3: ld_funct3});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_RegWrite", RegWrite, m_we);
            check("m_addr", WB_rd_addr, m_addr);
            check("m_data", WB_rd_data, m_data);
            check("m_funct3", funct3, m_f3);
            check("m_opcode", opcode, m_op);
            check("m_ld_ready", ld_ready, m_q.size() < LQ_DEPTH);
            check("m_rs1_busy", rs1_busy, m_sb[rs1_addr]);
            check("m_rs2_busy", rs2_busy, m_sb[rs2_addr]);
            check("m_alu_stall", alu_stall, m_force() && alu_valid);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0; ld_funct3 = 0;
        iss_valid = 0; iss_rd = 0; rs1_addr = 5'd7; rs2_addr = 5'd0;
        step();
        chk_en = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;

        @(negedge clk);
        check("rst RegWrite", RegWrite, 0);
        check("rst addr", WB_rd_addr, 0);
        check("rst data", WB_rd_data, 0);
        check("rst opcode", opcode, 0);
        check("rst funct3", funct3, 0);
        check("rst ld_ready", ld_ready, 1);
        check("rst rs1_busy", rs1_busy, 0);
        check("rst rs2_busy", rs2_busy, 0);
        check("rst alu_stall", alu_stall, 0);

        // ALU write appears one cycle after its grant.
        step(); alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        step(); alu_valid = 0;
        @(negedge clk);
        check("alu RegWrite", RegWrite, 1);
        check("alu addr", WB_rd_addr, 5);
        check("alu data", WB_rd_data, 32'hDEADBEEF);
        check("alu opcode", opcode, 7'b0110011);
        check("alu funct3", funct3, 0);

        // Issued load marks x7 busy until the cycle after its grant.
        step(); iss_valid = 1; iss_rd = 5'd7;
        step(); iss_valid = 0;
        ld_valid = 1; ld_rd = 5'd7; ld_data = 32'h000000F0; ld_funct3 = 3'b000;
        @(negedge clk);
        check("sb busy after issue", rs1_busy, 1);
        step(); ld_valid = 0;
        @(negedge clk);
        check("sb busy in grant cycle", rs1_busy, 1);
        check("no write in grant cycle", RegWrite, 0);
        step();
        @(negedge clk);
        check("sb clear after grant", rs1_busy, 0);
        check("ld RegWrite", RegWrite, 1);
        check("ld addr", WB_rd_addr, 7);
        check("ld data", WB_rd_data, 32'h000000F0);
        check("ld opcode", opcode, 7'b0000011);
        check("ld funct3", funct3, 3'b000);

        // Three load returns while the ALU holds the port; the third is refused.
        step(); alu_valid = 1; alu_rd = 5'd1; alu_data = 32'h111;
        ld_valid = 1; ld_rd = 5'd10; ld_data = 32'hA0; ld_funct3 = 3'd1;
        step(); alu_rd = 5'd2; alu_data = 32'h222;
        ld_rd = 5'd11; ld_data = 32'hB0; ld_funct3 = 3'd4;
        step(); alu_rd = 5'd3; alu_data = 32'h333;
        ld_rd = 5'd12; ld_data = 32'hC0; ld_funct3 = 3'd5;
        @(negedge clk);
        check("full ld_ready", ld_ready, 0);
        step(); ld_valid = 0; alu_rd = 5'd4; alu_data = 32'h444;
        @(negedge clk);
        check("alu wins opcode", opcode, 7'b0110011);
        check("alu wins addr", WB_rd_addr, 3);
        step();
        @(negedge clk);
        check("alu wins again", WB_rd_addr, 4);
        step(); alu_valid = 0;
        @(negedge clk);
        check("last alu addr", WB_rd_addr, 4);
        step();
        @(negedge clk);
        check("drain0 addr", WB_rd_addr, 10);
        check("drain0 data", WB_rd_data, 32'hA0);
        check("drain0 funct3", funct3, 3'd1);
        check("drain0 opcode", opcode, 7'b0000011);
        step();
        @(negedge clk);
        check("drain1 addr", WB_rd_addr, 11);
        check("drain1 funct3", funct3, 3'd4);
        step();
        @(negedge clk);
        check("refused load not written", RegWrite, 0);

`ifdef WB_STARVE_GUARD_EN
        // One queued load against a continuous ALU stream is forced on the 5th cycle.
        step(); alu_valid = 1; alu_rd = 5'd6; alu_data = 32'h666;
        ld_valid = 1; ld_rd = 5'd20; ld_data = 32'hC0; ld_funct3 = 3'd2;
        step(); ld_valid = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("starve alu_stall", alu_stall, (i == 5));
            step();
        end
        @(negedge clk);
        check("forced ld addr", WB_rd_addr, 20);
        check("forced ld opcode", opcode, 7'b0000011);
        check("forced ld funct3", funct3, 3'd2);
        check("stall released", alu_stall, 0);
        step();
        @(negedge clk);
        check("alu resumes addr", WB_rd_addr, 6);
        check("alu resumes opcode", opcode, 7'b0110011);
        alu_valid = 0;
`endif

        // Write to x0, then reset while a load is queued.
        step(); alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234;
        step(); alu_rd = 5'd8; alu_data = 32'h888;
        ld_valid = 1; ld_rd = 5'd9; ld_data = 32'hD0; ld_funct3 = 3'd0;
        @(negedge clk);
        check("x0 RegWrite", RegWrite, 0);
        check("x0 data held", WB_rd_data == 32'h1234, 0);
        step(); ld_valid = 0;
        step(); rst_n = 1'b0; alu_valid = 0;
        #1;
        check("mid rst RegWrite", RegWrite, 0);
        check("mid rst ld_ready", ld_ready, 1);
        check("mid rst data", WB_rd_data, 0);
        step(); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no stale write", RegWrite, 0);
            step();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
